// File: rtl/key_press_detect.sv
// key_press_detect: debounces one push-button and emits one-cycle short or long press pulses
module key_press_detect #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key,
    output logic [1:0] state,
    output logic       pressed
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic IDLE_LVL = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG_DONE, DEB_REL} fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          long_fired_q, long_fired_d;
    logic          pressed_q, pressed_d;
    logic [1:0]    pulse_q, pulse_d;
    logic          sync1_q, sync2_q;
    logic          p_s;
    logic          long_hit;

    assign p_s      = sync2_q ^ IDLE_LVL;
    assign long_hit = (hold_q >= HOLD_LAST);
    assign state    = pulse_q;
    assign pressed  = pressed_q;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1_q      <= IDLE_LVL;
            sync2_q      <= IDLE_LVL;
            fsm_q        <= IDLE;
            deb_q        <= '0;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            pressed_q    <= 1'b0;
            pulse_q      <= 2'b00;
        end else begin
            sync1_q      <= key;
            sync2_q      <= sync1_q;
            fsm_q        <= fsm_d;
            deb_q        <= deb_d;
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            pressed_q    <= pressed_d;
            pulse_q      <= pulse_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        deb_d        = deb_q;
        hold_d       = hold_q;
        long_fired_d = long_fired_q;
        pressed_d    = pressed_q;
        pulse_d      = 2'b00;
        case (fsm_q)
            IDLE: begin
                if (p_s) begin
                    fsm_d = DEB_PRESS;
                    deb_d = DW'(1);
                end
            end
            DEB_PRESS: begin
                if (!p_s) begin
                    fsm_d = IDLE;
                    deb_d = '0;
                end else if (deb_q >= DEB_MAX) begin
                    fsm_d        = HELD;
                    pressed_d    = 1'b1;
                    hold_d       = '0;
                    long_fired_d = 1'b0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                // a long threshold coinciding with release still fires the long pulse
                if (long_hit) begin
                    fsm_d        = LONG_DONE;
                    pulse_d      = 2'b10;
                    long_fired_d = 1'b1;
                end else if (p_s) begin
                    hold_d = hold_q + 1'b1;
                end
                if (!p_s) begin
                    fsm_d = DEB_REL;
                    deb_d = DW'(1);
                end
            end
            LONG_DONE: begin
                if (!p_s) begin
                    fsm_d        = DEB_REL;
                    deb_d        = DW'(1);
                    long_fired_d = 1'b1;
                end
            end
            DEB_REL: begin
                if (p_s) begin
                    fsm_d = long_fired_q ? LONG_DONE : HELD;
                    deb_d = '0;
                end else if (deb_q >= DEB_MAX) begin
                    fsm_d     = IDLE;
                    deb_d     = '0;
                    pressed_d = 1'b0;
                    pulse_d   = {1'b0, !long_fired_q};
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_key_press_detect.sv
// tb_key_press_detect: scoreboard bench driving an active-low and an active-high instance with mirrored keys
module tb_key_press_detect;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int LAT  = DEB + 3;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       pr;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b1;
    logic       key_b;
    logic [1:0] state_a, state_b;
    logic       pressed_a, pressed_b;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       e;

    assign key_b = ~key;

    key_press_detect #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .KEY_ACTIVE_LOW(1)) dut_a (
        .CLOCK_50(CLOCK_50), .rst(rst), .key(key), .state(state_a), .pressed(pressed_a)
    );

    key_press_detect #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .KEY_ACTIVE_LOW(0)) dut_b (
        .CLOCK_50(CLOCK_50), .rst(rst), .key(key_b), .state(state_b), .pressed(pressed_b)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("state_active_low", state_a, e.st);
            chk("pressed_active_low", {1'b0, pressed_a}, {1'b0, e.pr});
            chk("state_active_high", state_b, e.st);
            chk("pressed_active_high", {1'b0, pressed_b}, {1'b0, e.pr});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [1:0] st, input logic pr);
        exp_t x;
        x.cyc = c;
        x.st  = st;
        x.pr  = pr;
        sb.push_back(x);
    endtask

    task automatic exp_idle(input int a, input int b);
        for (int k = a; k <= b; k++) push(k, 2'b00, 1'b0);
    endtask

    // clean press of `low` cycles starting just after edge f
    task automatic exp_press(input int f, input int low);
        logic       is_long;
        logic [1:0] st;
        is_long = (low >= LONG + DEB);
        for (int k = f + 1; k <= f + low + LAT + 2; k++) begin
            if (is_long) st = (k == f + LAT + LONG) ? 2'b10 : 2'b00;
            else         st = (k == f + low + LAT) ? 2'b01 : 2'b00;
            push(k, st, (k >= f + LAT) && (k < f + low + LAT));
        end
    endtask

    task automatic press(input int low);
        int f;
        f = cyc;
        exp_press(f, low);
        key = 1'b0;
        tick(low);
        key = 1'b1;
        tick(LAT + 2);
    endtask

    initial begin
        int f;
        exp_idle(1, 4);
        tick(4);
        rst = 1'b0;
        exp_idle(5, 8);
        tick(4);
        press(12);
        press(40);
        f = cyc;
        exp_idle(f + 1, f + 16);
        key = 1'b0; tick(2);
        key = 1'b1; tick(3);
        key = 1'b0; tick(1);
        key = 1'b1; tick(10);
        f = cyc;
        exp_press(f, 17);
        key = 1'b0; tick(10);
        key = 1'b1; tick(2);
        key = 1'b0; tick(5);
        key = 1'b1; tick(LAT + 2);
        press(LONG + DEB - 1);
        press(LONG + DEB);
        f = cyc;
        for (int k = f + 1; k <= f + 12; k++) push(k, 2'b00, k >= f + LAT);
        exp_idle(f + 13, f + 30);
        key = 1'b0; tick(12);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        key = 1'b1; tick(17);
        press(12);
        tick(2);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
